// File: rtl/mil_receiver.sv
// MIL-STD-1553 Manchester II word receiver: detects the 3-bit-time sync, decodes
// 16 data bits plus odd parity, and reports good words or abort codes as one-cycle pulses.
module mil_receiver #(
  parameter int CLK_PER_BIT = 50,
  parameter int SYNC_TOL    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mil_p,
  input  logic        mil_n,
  output logic        rx_valid,
  output logic        rx_type,
  output logic [15:0] rx_data,
  output logic        rx_error,
  output logic [1:0]  rx_err_code,
  output logic        busy
);
  localparam int B  = CLK_PER_BIT;
  localparam int CW = $clog2(2 * B + 1);
  localparam logic [CW-1:0] C_ZERO  = CW'(0);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_Q     = CW'(B / 4);
  localparam logic [CW-1:0] C_Q3    = CW'((3 * B) / 4);
  localparam logic [CW-1:0] C_BM1   = CW'(B - 1);
  localparam logic [CW-1:0] C_HBM1  = CW'(B / 2 - 1);
  localparam logic [CW-1:0] C_SB_END = CW'((3 * B) / 2 - 1);
  localparam logic [CW-1:0] C_SLO   = CW'((3 * B) / 2 - SYNC_TOL);
  localparam logic [CW-1:0] C_SHI   = CW'((3 * B) / 2 + SYNC_TOL);

  typedef enum logic [1:0] {LV_IDLE, LV_HI, LV_LO} level_t;
  typedef enum logic [2:0] {S_IDLE, S_SYNC_A, S_SYNC_B, S_BITS, S_WAIT_IDLE} state_t;

  // Odd parity holds when the word including its parity bit has an odd count of ones.
  function automatic logic odd_parity_ok(input logic [16:0] w);
    return ^w;
  endfunction

  logic          p_s1_r, p_s2_r, n_s1_r, n_s2_r;
  level_t        lvl_s, nota_s, a_r, a_n, half_r, half_n;
  state_t        state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n, cnt_inc_s;
  logic [4:0]    bit_r, bit_n;
  logic          pre_r, pre_n, pend_r, pend_n, wtype_r, wtype_n, bitv_s;
  logic [15:0]   shift_r, shift_n, data_n;
  logic          valid_n, error_n, rtype_n;
  logic [1:0]    code_n;
  logic          rx_valid_r, rx_type_r, rx_error_r, busy_r;
  logic [15:0]   rx_data_r;
  logic [1:0]    rx_err_code_r;

  assign nota_s    = (a_r == LV_HI) ? LV_LO : LV_HI;
  assign bitv_s    = (half_r == LV_HI);
  assign cnt_inc_s = cnt_r + C_ONE;

  // Line level decode from the synchronised legs.
  always_comb begin
    lvl_s = LV_IDLE;
    if (p_s2_r && !n_s2_r) lvl_s = LV_HI;
    else if (!p_s2_r && n_s2_r) lvl_s = LV_LO;
    else lvl_s = LV_IDLE;
  end

  // Next-state and output decisions.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_inc_s;
    bit_n   = bit_r;
    a_n     = a_r;
    pre_n   = pre_r;
    pend_n  = pend_r;
    half_n  = half_r;
    shift_n = shift_r;
    wtype_n = wtype_r;
    valid_n = 1'b0;
    error_n = 1'b0;
    code_n  = rx_err_code_r;
    data_n  = rx_data_r;
    rtype_n = rx_type_r;
    case (state_r)
      S_IDLE: begin
        if (lvl_s != LV_IDLE) begin
          state_n = S_SYNC_A;
          a_n     = lvl_s;
          pre_n   = 1'b0;
          pend_n  = 1'b0;
          cnt_n   = C_ONE;
        end else begin
          cnt_n = C_ZERO;
        end
      end
      S_SYNC_A: begin
        if (lvl_s == LV_IDLE) begin
          state_n = S_IDLE;
          cnt_n   = C_ZERO;
        end else if (pre_r) begin
          // Run out the remainder of the previous parity bit up to the bit boundary t0.
          if (cnt_r == C_BM1) begin
            cnt_n = C_ZERO;
            pre_n = 1'b0;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end else if (pend_r) begin
          if (cnt_r == C_Q) begin
            a_n    = lvl_s;
            pend_n = 1'b0;
          end else begin
            pend_n = 1'b1;
          end
        end else if (lvl_s != a_r) begin
          if (cnt_r >= C_SLO && cnt_r <= C_SHI) begin
            state_n = S_SYNC_B;
            cnt_n   = C_ONE;
            wtype_n = (a_r == LV_LO);
          end else begin
            state_n = S_WAIT_IDLE;
            cnt_n   = C_ZERO;
            error_n = 1'b1;
            code_n  = 2'd1;
          end
        end else if (cnt_r > C_SHI) begin
          state_n = S_WAIT_IDLE;
          cnt_n   = C_ZERO;
          error_n = 1'b1;
          code_n  = 2'd1;
        end else begin
          cnt_n = cnt_inc_s;
        end
      end
      S_SYNC_B: begin
        if (lvl_s != nota_s) begin
          state_n = S_WAIT_IDLE;
          cnt_n   = C_ZERO;
          error_n = 1'b1;
          code_n  = 2'd1;
        end else if (cnt_r == C_SB_END) begin
          state_n = S_BITS;
          cnt_n   = C_ZERO;
          bit_n   = 5'd0;
        end else begin
          cnt_n = cnt_inc_s;
        end
      end
      S_BITS: begin
        if (cnt_r == C_Q) begin
          half_n = lvl_s;
        end else if (cnt_r == C_Q3) begin
          if (half_r == LV_IDLE || lvl_s == LV_IDLE || half_r == lvl_s) begin
            state_n = S_WAIT_IDLE;
            cnt_n   = C_ZERO;
            error_n = 1'b1;
            code_n  = 2'd2;
          end else if (bit_r == 5'd16) begin
            if (odd_parity_ok({shift_r, bitv_s})) begin
              valid_n = 1'b1;
              data_n  = shift_r;
              rtype_n = wtype_r;
            end else begin
              error_n = 1'b1;
              code_n  = 2'd3;
            end
            // Continue straight into the next word's sync; its level is taken after t0.
            state_n = S_SYNC_A;
            pre_n   = 1'b1;
            pend_n  = 1'b1;
          end else begin
            shift_n = {shift_r[14:0], bitv_s};
          end
        end else if (cnt_r == C_BM1) begin
          cnt_n = C_ZERO;
          bit_n = bit_r + 5'd1;
        end else begin
          cnt_n = cnt_inc_s;
        end
      end
      S_WAIT_IDLE: begin
        if (lvl_s == LV_IDLE) begin
          if (cnt_r == C_HBM1) begin
            state_n = S_IDLE;
            cnt_n   = C_ZERO;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end else begin
          cnt_n = C_ZERO;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = C_ZERO;
      end
    endcase
  end

  // State, synchronisers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_s1_r        <= 1'b0;
      p_s2_r        <= 1'b0;
      n_s1_r        <= 1'b0;
      n_s2_r        <= 1'b0;
      state_r       <= S_IDLE;
      cnt_r         <= C_ZERO;
      bit_r         <= 5'd0;
      a_r           <= LV_IDLE;
      half_r        <= LV_IDLE;
      pre_r         <= 1'b0;
      pend_r        <= 1'b0;
      shift_r       <= 16'h0000;
      wtype_r       <= 1'b0;
      rx_valid_r    <= 1'b0;
      rx_type_r     <= 1'b0;
      rx_data_r     <= 16'h0000;
      rx_error_r    <= 1'b0;
      rx_err_code_r <= 2'd0;
      busy_r        <= 1'b0;
    end else begin
      p_s1_r        <= mil_p;
      p_s2_r        <= p_s1_r;
      n_s1_r        <= mil_n;
      n_s2_r        <= n_s1_r;
      state_r       <= state_n;
      cnt_r         <= cnt_n;
      bit_r         <= bit_n;
      a_r           <= a_n;
      half_r        <= half_n;
      pre_r         <= pre_n;
      pend_r        <= pend_n;
      shift_r       <= shift_n;
      wtype_r       <= wtype_n;
      rx_valid_r    <= valid_n;
      rx_type_r     <= rtype_n;
      rx_data_r     <= data_n;
      rx_error_r    <= error_n;
      rx_err_code_r <= code_n;
      busy_r        <= (state_n != S_IDLE);
    end
  end

  assign rx_valid    = rx_valid_r;
  assign rx_type     = rx_type_r;
  assign rx_data     = rx_data_r;
  assign rx_error    = rx_error_r;
  assign rx_err_code = rx_err_code_r;
  assign busy        = busy_r;
endmodule

// File: tb/tb_mil_receiver.sv
// Bench for mil_receiver: drives Manchester words built from a word description and
// compares decoded events against outcomes and timing predicted from the word rules.
module tb_mil_receiver;
  localparam int B = 50;
  localparam int TOL = 5;

  logic clk = 1'b0;
  logic rst, mil_p, mil_n;
  logic rx_valid, rx_type, rx_error, busy;
  logic [15:0] rx_data;
  logic [1:0] rx_err_code;

  mil_receiver #(.CLK_PER_BIT(B), .SYNC_TOL(TOL)) dut (
    .clk(clk), .rst(rst), .mil_p(mil_p), .mil_n(mil_n),
    .rx_valid(rx_valid), .rx_type(rx_type), .rx_data(rx_data),
    .rx_error(rx_error), .rx_err_code(rx_err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; logic typ; logic [15:0] d; } vev_t;
  typedef struct { int t; logic [1:0] c; } eev_t;
  typedef struct { logic typ; logic [15:0] d; bit flip; int bad; int fh; int code; } vec_t;

  vev_t vq[$];
  eev_t eq[$];
  int both_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) vq.push_back('{cyc, rx_type, rx_data});
      if (rx_error) eq.push_back('{cyc, rx_err_code});
      if (rx_valid && rx_error) both_cnt <= both_cnt + 1;
    end
  end

  int n_vec = 0, n_mis = 0;
  logic [15:0] last_good = 16'h0000;
  int v0, e0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // lv: 0 idle, 1 HI, 2 LO; held for n clock cycles
  task automatic line(input int lv, input int n);
    mil_p = (lv == 1);
    mil_n = (lv == 2);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic typ, input logic [15:0] d, input bit flip,
                           input int bad, input int fh, input int stop_at, output int edge_c);
    int a, na;
    logic par, b;
    a  = typ ? 2 : 1;
    na = typ ? 1 : 2;
    par = ~^d;
    if (flip) par = ~par;
    line(a, fh);
    check("busy_in_sync", busy, 1);
    edge_c = cyc;
    line(na, 75);
    for (int k = 0; k < 17; k++) begin
      if (k == stop_at) return;
      b = (k < 16) ? d[15 - k] : par;
      if (k == bad) line(b ? 1 : 2, B);
      else begin
        line(b ? 1 : 2, B / 2);
        line(b ? 2 : 1, B / 2);
      end
    end
  endtask

  // Outcome from the word rules: 0 good, else error code.
  function automatic int predict(input int fh, input int bad, input bit flip);
    if (fh < 75 - TOL || fh > 75 + TOL) return 1;
    if (bad >= 0) return 2;
    if (flip) return 3;
    return 0;
  endfunction

  task automatic eval_word(input string tag, input int code, input logic typ,
                           input logic [15:0] d, input int edge_c, input int bad);
    int nv, ne, t_exp;
    nv = vq.size() - v0;
    ne = eq.size() - e0;
    t_exp = (code == 2) ? edge_c + 2 + 75 + B * bad + 37 + 1 : edge_c + 915;
    check({tag, " n_valid"}, nv, (code == 0) ? 1 : 0);
    check({tag, " n_error"}, ne, (code == 0) ? 0 : 1);
    if (code == 0 && nv > 0) begin
      check({tag, " type"}, vq[v0].typ, typ);
      check({tag, " data"}, vq[v0].d, d);
      check({tag, " valid_time"}, vq[v0].t, t_exp);
      last_good = d;
    end
    if (code != 0 && ne > 0) begin
      check({tag, " err_code"}, eq[e0].c, code);
      if (code != 1) check({tag, " err_time"}, eq[e0].t, t_exp);
      check({tag, " err_code_held"}, rx_err_code, code);
    end
    check({tag, " data_held"}, rx_data, last_good);
    check({tag, " busy_idle"}, busy, 0);
  endtask

  vec_t tbl[0:8];
  int e1, e2;

  initial begin
    tbl[0] = '{1'b0, 16'h02A1, 1'b0, -1, 75, 0};
    tbl[1] = '{1'b1, 16'h00FF, 1'b1, -1, 75, 3};
    tbl[2] = '{1'b0, 16'h1234, 1'b0,  5, 75, 2};
    tbl[3] = '{1'b1, 16'hA5A5, 1'b0, -1, 75, 0};
    tbl[4] = '{1'b0, 16'h02A1, 1'b0, -1, 60, 1};
    tbl[5] = '{1'b0, 16'h02A1, 1'b0, -1, 80, 0};
    tbl[6] = '{1'b1, 16'hFFFF, 1'b0, -1, 70, 0};
    tbl[7] = '{1'b1, 16'h0000, 1'b0, -1, 75, 0};
    tbl[8] = '{1'b0, 16'h8001, 1'b0, 16, 75, 2};

    rst = 1'b1; mil_p = 1'b0; mil_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_error", rx_error, 0);
    check("reset rx_data", rx_data, 0);
    check("reset rx_type_code_busy", {rx_type, rx_err_code, busy}, 0);
    rst = 1'b0;
    line(0, 10);

    for (int i = 0; i < 9; i++) begin
      v0 = vq.size(); e0 = eq.size();
      send_word(tbl[i].typ, tbl[i].d, tbl[i].flip, tbl[i].bad, tbl[i].fh, 17, e1);
      line(0, 60);
      eval_word($sformatf("tbl%0d", i), tbl[i].code, tbl[i].typ, tbl[i].d, e1, tbl[i].bad);
    end

    // Back-to-back command then data word, no gap
    v0 = vq.size(); e0 = eq.size();
    send_word(1'b0, 16'h02A1, 1'b0, -1, 75, 17, e1);
    send_word(1'b1, 16'h02A1, 1'b0, -1, 75, 17, e2);
    line(0, 60);
    check("contig n_valid", vq.size() - v0, 2);
    check("contig n_error", eq.size() - e0, 0);
    if (vq.size() - v0 == 2) begin
      check("contig first_time", vq[v0].t, e1 + 915);
      check("contig pitch", vq[v0 + 1].t - vq[v0].t, 20 * B);
      check("contig types", {vq[v0].typ, vq[v0 + 1].typ}, 2'b01);
      check("contig data2", vq[v0 + 1].d, 16'h02A1);
    end
    last_good = 16'h02A1;

    // Manchester error, exactly 25 idle cycles, then a good word
    v0 = vq.size(); e0 = eq.size();
    send_word(1'b0, 16'h1234, 1'b0, 5, 75, 17, e1);
    line(0, 25);
    send_word(1'b1, 16'hA5A5, 1'b0, -1, 75, 17, e2);
    line(0, 60);
    check("recover n_error", eq.size() - e0, 1);
    check("recover n_valid", vq.size() - v0, 1);
    if (eq.size() - e0 == 1) check("recover err_time", eq[e0].t, e1 + 2 + 75 + 5 * B + 38);
    if (vq.size() - v0 == 1) begin
      check("recover data", vq[v0].d, 16'hA5A5);
      check("recover time", vq[v0].t, e2 + 915);
    end
    last_good = 16'hA5A5;

    // Randomised words against the rule model
    for (int i = 0; i < 14; i++) begin
      logic typ; logic [15:0] d; bit flip; int bad, fh, code;
      typ  = 1'($urandom_range(0, 1));
      d    = 16'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : -1;
      fh   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(55, 95)) : int'($urandom_range(70, 80));
      code = predict(fh, bad, flip);
      v0 = vq.size(); e0 = eq.size();
      send_word(typ, d, flip, bad, fh, 17, e1);
      line(0, 60);
      eval_word($sformatf("rnd%0d", i), code, typ, d, e1, bad);
    end

    // Reset during bit 8 discards the word
    v0 = vq.size(); e0 = eq.size();
    send_word(1'b0, 16'hBEEF, 1'b0, -1, 75, 8, e1);
    rst = 1'b1; mil_p = 1'b0; mil_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst rx_data", rx_data, 0);
    check("midrst flags", {rx_valid, rx_error, rx_type, rx_err_code, busy}, 0);
    rst = 1'b0;
    last_good = 16'h0000;
    line(0, 60);
    check("midrst no_events", (vq.size() - v0) + (eq.size() - e0), 0);
    v0 = vq.size(); e0 = eq.size();
    send_word(1'b0, 16'h1234, 1'b0, -1, 75, 17, e1);
    line(0, 60);
    eval_word("after_rst", 0, 1'b0, 16'h1234, e1, -1);

    check("valid_error_overlap", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
